// File: rtl/ex_stage.sv
// ex_stage: RV32I execute stage. Computes the ALU result, resolves conditional
// branches, and registers the result into the EX/MEM boundary. Both sides use a
// valid/ready handshake. A taken branch produces a one-cycle redirect toward
// fetch, and any instruction accepted in that cycle is killed.
// Optional macro EX_PERF_CNT_EN adds the perf_insn / perf_taken counters.

package riscv_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_BGE  = 3'd4,
    BR_BLTU = 3'd5,
    BR_BGEU = 3'd6
  } branch_e;
endpackage

module ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_rs1,
  input  logic [XLEN-1:0]   in_rs2,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              in_use_imm,
  input  alu_op_e           in_alu_op,
  input  branch_e           in_branch,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_rd_we,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_rd_we,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc
`ifdef EX_PERF_CNT_EN
  ,
  output logic [31:0]       perf_insn,
  output logic [31:0]       perf_taken
`endif
);

  localparam int SHW = $clog2(XLEN);

  logic              out_valid_r;
  logic [XLEN-1:0]   out_result_r;
  logic [REG_AW-1:0] out_rd_r;
  logic              out_rd_we_r;
  logic              redirect_valid_r;
  logic [XLEN-1:0]   redirect_pc_r;

  logic [XLEN-1:0]   op_b_s;
  logic [SHW-1:0]    shamt_s;
  logic [XLEN-1:0]   alu_result_s;
  logic              taken_s;
  logic [XLEN-1:0]   target_s;
  logic              accept_s;

  // No skid buffer: the stage can take a new instruction when the output slot
  // is empty or is being drained this cycle.
  assign in_ready = !out_valid_r || out_ready;

  // An accept is discarded by flush and by the wrong-path slot after a redirect.
  assign accept_s = in_valid && in_ready && !flush && !redirect_valid_r;

  assign op_b_s   = in_use_imm ? in_imm : in_rs2;
  assign shamt_s  = op_b_s[SHW-1:0];
  assign target_s = in_pc + in_imm;

  // ALU result; unknown opcodes produce zero.
  always_comb begin
    alu_result_s = {XLEN{1'b0}};
    case (in_alu_op)
      ALU_ADD:  alu_result_s = in_rs1 + op_b_s;
      ALU_SUB:  alu_result_s = in_rs1 - op_b_s;
      ALU_SLL:  alu_result_s = in_rs1 << shamt_s;
      ALU_SLT:  alu_result_s = {{(XLEN-1){1'b0}}, ($signed(in_rs1) < $signed(op_b_s))};
      ALU_SLTU: alu_result_s = {{(XLEN-1){1'b0}}, (in_rs1 < op_b_s)};
      ALU_XOR:  alu_result_s = in_rs1 ^ op_b_s;
      ALU_SRL:  alu_result_s = in_rs1 >> shamt_s;
      ALU_SRA:  alu_result_s = $unsigned($signed(in_rs1) >>> shamt_s);
      ALU_OR:   alu_result_s = in_rs1 | op_b_s;
      ALU_AND:  alu_result_s = in_rs1 & op_b_s;
      default:  alu_result_s = {XLEN{1'b0}};
    endcase
  end

  // Branch condition, always rs1 against rs2 regardless of use_imm.
  always_comb begin
    taken_s = 1'b0;
    case (in_branch)
      BR_BEQ:  taken_s = (in_rs1 == in_rs2);
      BR_BNE:  taken_s = (in_rs1 != in_rs2);
      BR_BLT:  taken_s = ($signed(in_rs1) < $signed(in_rs2));
      BR_BGE:  taken_s = ($signed(in_rs1) >= $signed(in_rs2));
      BR_BLTU: taken_s = (in_rs1 < in_rs2);
      BR_BGEU: taken_s = (in_rs1 >= in_rs2);
      default: taken_s = 1'b0;
    endcase
  end

  // EX/MEM output register: flush wins, then a new accept, then a drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      out_result_r <= {XLEN{1'b0}};
      out_rd_r     <= {REG_AW{1'b0}};
      out_rd_we_r  <= 1'b0;
    end else if (flush) begin
      out_valid_r  <= 1'b0;
    end else if (accept_s) begin
      out_valid_r  <= 1'b1;
      out_result_r <= alu_result_s;
      out_rd_r     <= in_rd;
      out_rd_we_r  <= in_rd_we && (in_rd != {REG_AW{1'b0}});
    end else if (out_ready) begin
      out_valid_r  <= 1'b0;
    end
  end

  // Redirect pulse: one cycle after a taken, surviving accept, ignoring out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= {XLEN{1'b0}};
    end else begin
      redirect_valid_r <= accept_s && taken_s;
      if (accept_s && taken_s) begin
        redirect_pc_r <= target_s;
      end
    end
  end

  assign out_valid      = out_valid_r;
  assign out_result     = out_result_r;
  assign out_rd         = out_rd_r;
  assign out_rd_we      = out_rd_we_r;
  assign redirect_valid = redirect_valid_r;
  assign redirect_pc    = redirect_pc_r;

`ifdef EX_PERF_CNT_EN
  logic [31:0] perf_insn_r;
  logic [31:0] perf_taken_r;

  // Saturating counters of surviving instructions and of generated redirects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_insn_r  <= 32'h0000_0000;
      perf_taken_r <= 32'h0000_0000;
    end else begin
      if (accept_s && (perf_insn_r != 32'hFFFF_FFFF)) begin
        perf_insn_r <= perf_insn_r + 32'd1;
      end
      if (accept_s && taken_s && (perf_taken_r != 32'hFFFF_FFFF)) begin
        perf_taken_r <= perf_taken_r + 32'd1;
      end
    end
  end

  assign perf_insn  = perf_insn_r;
  assign perf_taken = perf_taken_r;
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage with hand-computed expectations.
module tb_ex_stage;
  import riscv_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [31:0] in_imm;
  logic        in_use_imm;
  alu_op_e     in_alu_op;
  branch_e     in_branch;
  logic [4:0]  in_rd;
  logic        in_rd_we;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef EX_PERF_CNT_EN
  logic [31:0] perf_insn;
  logic [31:0] perf_taken;
`endif

  int n_checks;
  int n_pass;

  ex_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_alu_op(in_alu_op), .in_branch(in_branch),
    .in_rd(in_rd), .in_rd_we(in_rd_we),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_rd_we(out_rd_we),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef EX_PERF_CNT_EN
    , .perf_insn(perf_insn), .perf_taken(perf_taken)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic use_imm, input alu_op_e op,
                       input branch_e br, input logic [4:0] rd, input logic we);
    in_valid   = 1'b1;
    in_pc      = pc;
    in_rs1     = rs1;
    in_rs2     = rs2;
    in_imm     = imm;
    in_use_imm = use_imm;
    in_alu_op  = op;
    in_branch  = br;
    in_rd      = rd;
    in_rd_we   = we;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_pc = 32'd0; in_rs1 = 32'd0; in_rs2 = 32'd0; in_imm = 32'd0;
    in_use_imm = 1'b0; in_alu_op = ALU_ADD; in_branch = BR_NONE; in_rd = 5'd0; in_rd_we = 1'b0;

    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // ADD wrap
    drive(32'h0, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b1, ALU_ADD, BR_NONE, 5'd5, 1'b1);
    step();
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_result", out_result, 32'h0000_0000);
    chk("add_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("add_rd", {27'd0, out_rd}, 32'd5);
    chk("add_rd_we", {31'd0, out_rd_we}, 32'd1);

    // SRA uses only the low 5 bits of rs2
    drive(32'h0, 32'h8000_0000, 32'h0000_0024, 32'h0, 1'b0, ALU_SRA, BR_NONE, 5'd6, 1'b1);
    step();
    chk("sra_result", out_result, 32'hF800_0000);

    drive(32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, ALU_SLT, BR_NONE, 5'd6, 1'b1);
    step();
    chk("slt_result", out_result, 32'h1);

    // SLTU to x0: write enable must be dropped
    drive(32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, ALU_SLTU, BR_NONE, 5'd0, 1'b1);
    step();
    chk("sltu_result", out_result, 32'h0);
    chk("x0_rd_we", {31'd0, out_rd_we}, 32'd0);

    drive(32'h0, 32'h0, 32'h1, 32'h0, 1'b0, ALU_SUB, BR_NONE, 5'd7, 1'b1);
    step();
    chk("sub_wrap", out_result, 32'hFFFF_FFFF);

    drive(32'h0, 32'h3, 32'd33, 32'h0, 1'b0, ALU_SLL, BR_NONE, 5'd7, 1'b1);
    step();
    chk("sll_mask", out_result, 32'h6);

    drive(32'h0, 32'h1234_5678, 32'h1, 32'h0, 1'b0, alu_op_e'(4'd15), BR_NONE, 5'd7, 1'b1);
    step();
    chk("undef_op", out_result, 32'h0);

    // BLT taken: rs1=-5 < rs2=3, target 0x100-16
    drive(32'h100, 32'hFFFF_FFFB, 32'h3, 32'hFFFF_FFF0, 1'b0, ALU_ADD, BR_BLT, 5'd1, 1'b1);
    step();
    chk("blt_redirect", {31'd0, redirect_valid}, 32'd1);
    chk("blt_target", redirect_pc, 32'h0000_00F0);
    chk("blt_valid", {31'd0, out_valid}, 32'd1);
    chk("blt_result", out_result, 32'hFFFF_FFFE);
    chk("blt_rd_we", {31'd0, out_rd_we}, 32'd1);

    // Wrong-path instruction in the redirect cycle
    drive(32'h104, 32'h1, 32'h0, 32'h1, 1'b1, ALU_ADD, BR_NONE, 5'd2, 1'b1);
    #1;
    chk("kill_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("kill_valid", {31'd0, out_valid}, 32'd0);
    chk("redirect_pulse_end", {31'd0, redirect_valid}, 32'd0);

    // BGE not taken (signed -5 < 3)
    drive(32'h200, 32'hFFFF_FFFB, 32'h3, 32'h20, 1'b0, ALU_SUB, BR_BGE, 5'd3, 1'b1);
    step();
    chk("bge_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("bge_valid", {31'd0, out_valid}, 32'd1);
    chk("bge_result", out_result, 32'hFFFF_FFF8);

    // BGEU taken (unsigned 0xFFFFFFFB >= 3)
    drive(32'h200, 32'hFFFF_FFFB, 32'h3, 32'h20, 1'b0, ALU_ADD, BR_BGEU, 5'd3, 1'b1);
    step();
    chk("bgeu_redirect", {31'd0, redirect_valid}, 32'd1);
    chk("bgeu_target", redirect_pc, 32'h0000_0220);
    in_valid = 1'b0;
    step();
    chk("idle_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_redirect", {31'd0, redirect_valid}, 32'd0);

    // Backpressure
    drive(32'h0, 32'd10, 32'h0, 32'd5, 1'b1, ALU_ADD, BR_NONE, 5'd3, 1'b1);
    step();
    chk("bp_first", out_result, 32'd15);
    out_ready = 1'b0;
    drive(32'h0, 32'd20, 32'h0, 32'd5, 1'b1, ALU_ADD, BR_NONE, 5'd4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      step();
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold", out_result, 32'd15);
      chk("bp_rd", {27'd0, out_rd}, 32'd3);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("b2b_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_result", out_result, 32'd25);
    in_valid = 1'b0;
    step();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);

    // Flush beats a taken BEQ accepted in the same cycle
    drive(32'h0, 32'd1, 32'h0, 32'd1, 1'b1, ALU_ADD, BR_NONE, 5'd6, 1'b1);
    step();
    chk("pre_flush_valid", {31'd0, out_valid}, 32'd1);
    drive(32'h300, 32'd7, 32'd7, 32'h40, 1'b0, ALU_ADD, BR_BEQ, 5'd6, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);

    // BNE taken, then asynchronous reset mid-operation
    drive(32'h0, 32'd1, 32'd2, 32'd8, 1'b0, ALU_ADD, BR_BNE, 5'd9, 1'b1);
    step();
    in_valid = 1'b0;
    chk("bne_valid", {31'd0, out_valid}, 32'd1);
    chk("bne_result", out_result, 32'd3);
    chk("bne_redirect", {31'd0, redirect_valid}, 32'd1);
`ifdef EX_PERF_CNT_EN
    chk("perf_insn", perf_insn, 32'd14);
    chk("perf_taken", perf_taken, 32'd3);
`endif
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_result", out_result, 32'd0);
    chk("async_rst_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("async_rst_pc", redirect_pc, 32'd0);
`ifdef EX_PERF_CNT_EN
    chk("rst_perf_insn", perf_insn, 32'd0);
    chk("rst_perf_taken", perf_taken, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    drive(32'h0, 32'd4, 32'h0, 32'd4, 1'b1, ALU_ADD, BR_NONE, 5'd8, 1'b1);
    step();
    in_valid = 1'b0;
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("post_rst_result", out_result, 32'd8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the RV32I pipeline, directly downstream of ALU/branch decode.
- Consumes the decoded alu_op_e / branch_e plus operands, computes the ALU result, resolves conditional branches, and registers results into the EX/MEM boundary.
- Uses a valid/ready handshake on both sides, a one-cycle redirect pulse toward fetch, and a flush input.

Parameters:
- XLEN, 32, datapath width in bits.
- REG_AW, 5, register-file address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  kill the in-flight output and any input accepted this cycle.
- in_valid  in  1  upstream transaction valid.
- in_ready  out  1  stage can accept.
- in_pc  in  XLEN  instruction PC.
- in_rs1  in  XLEN  operand A.
- in_rs2  in  XLEN  register operand B; also the branch compare operand.
- in_imm  in  XLEN  sign-extended immediate.
- in_use_imm  in  1  ALU operand B = in_imm when 1, else in_rs2.
- in_alu_op  in  alu_op_e  ALU operation (riscv_pkg).
- in_branch  in  branch_e  branch type; BR_NONE means not a branch.
- in_rd  in  REG_AW  destination register.
- in_rd_we  in  1  destination write enable.
- out_valid  out  1  EX/MEM result valid.
- out_ready  in  1  downstream accepts.
- out_result  out  XLEN  registered ALU result.
- out_rd  out  REG_AW  registered destination.
- out_rd_we  out  1  registered write enable; forced 0 when out_rd==0.
- redirect_valid  out  1  one-cycle taken-branch pulse.
- redirect_pc  out  XLEN  branch target.

Behaviour:
- Reset: asserting rst clears every registered output to 0 immediately (asynchronous).
  - Deasserting rst lets the first accept happen on the next rising edge.
  - Reset mid-transfer drops that transaction silently.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational, no skid buffer).
  - Accept condition: in_valid && in_ready.
  - Latency: result appears on out_* the cycle after accept.
  - out_* hold stable while out_valid && !out_ready.
  - out_valid drops when out_ready is high and nothing new is accepted.
- ALU, with B = in_use_imm ? in_imm : in_rs2 and all results modulo 2^XLEN:
  - ADD and SUB wrap.
  - SLT is signed; SLTU is unsigned; both produce 0 or 1.
  - SLL, SRL and SRA shift by B[$clog2(XLEN)-1:0] only; SRA sign-fills.
  - AND, OR, XOR are bitwise.
  - Any undefined enum value yields a result of 0.
- Branch, compared on in_rs1 vs in_rs2 (never imm):
  - BEQ: equal. BNE: not equal.
  - BLT / BGE: signed less-than / signed greater-or-equal.
  - BLTU / BGEU: unsigned versions of the same.
  - Target = in_pc + in_imm, wrapping.
  - If the branch is taken on an accepted transaction, the next cycle has redirect_valid=1 and redirect_pc=target for exactly one cycle, independent of out_ready.
  - A not-taken branch or BR_NONE never asserts redirect_valid.
  - The branch still passes to out_* with its in_rd_we.
- Wrong-path kill: in the cycle redirect_valid=1, any transaction accepted (in_ready is still driven normally) is discarded.
  - No out_valid and no redirect are produced for it.
- Flush:
  - flush=1 at a clock edge clears out_valid and discards that cycle's accept.
  - It also suppresses any redirect that would have been generated by that accept.
  - An already-asserted redirect_valid is not cancelled.
  - flush has priority over out_ready / accept.
- out_rd_we is 0 whenever out_rd==0, since x0 writes are never exported.

Optional Feature:
- Macro: EX_PERF_CNT_EN.
- When defined, adds output ports perf_insn (32b) and perf_taken (32b).
  - perf_insn counts accepted, non-killed, non-flushed transactions.
  - perf_taken counts asserted redirects.
  - Both saturate at 32'hFFFF_FFFF and async-reset to 0.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- ADD wrap: rs1=32'hFFFF_FFFF, imm=1, use_imm=1, ALU_ADD, out_ready=1 → next cycle out_valid=1, out_result=0, redirect_valid=0.
- Shift and compare ops:
  - SRA with rs1=32'h8000_0000, rs2=32'h0000_0024 (shamt 4) → out_result=32'hF800_0000.
  - SLT with rs1=-1, rs2=1 → 1.
  - SLTU with the same operands → 0.
- Branch taken, then wrong-path kill: BLT with rs1=-5, rs2=3, pc=32'h100, imm=-16 → redirect_valid pulse for 1 cycle with redirect_pc=32'hF0. An instruction accepted in that pulse cycle never appears on out_valid.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 → in_ready=0 and out_* stable. Releasing out_ready while in_valid=1 gives a back-to-back transfer with no bubble.
- Flush priority: flush=1 in the same cycle as accepting a taken BEQ (rs1=rs2=7) → no redirect, and out_valid=0 next cycle.
- Reset mid-operation: assert rst asynchronously while out_valid=1 → out_valid, out_result and redirect_valid go to 0 before the next edge. With EX_PERF_CNT_EN, both counters also read 0.
